// File: rtl/sfx_arbiter.sv
// sfx_arbiter
//   Shares the single Sound_Top channel (3-bit SoundSelect) between game-event
//   requesters. One pending bit per source, fixed priority (highest index wins),
//   preemption of lower-priority effects, per-source play length in frames and
//   a silent gap after each completed effect.
//
// Ports
//   Clk          in   system clock
//   Reset        in   synchronous, active-high
//   frame_clk    in   VGA_VS, asynchronous; frame timebase
//   flush        in   synchronous abort: drop everything and go idle
//   req          in   [NUM_REQ] request pulses, bit i = source i
//   sound_select out  [3] 0 = silence, i+1 = source i playing
//   grant        out  [NUM_REQ] one-hot playing source, 0 when silent
//   busy         out  high while playing or in the gap
//   done         out  1-cycle pulse when an effect ran its full length
//   preempted    out  1-cycle pulse when a playing effect was displaced
module sfx_arbiter #(
    parameter int                           NUM_REQ    = 3,
    parameter int                           DUR_W      = 8,
    parameter logic [NUM_REQ*DUR_W-1:0]     DUR_FRAMES = {8'd90, 8'd15, 8'd10},
    parameter int                           GAP_FRAMES = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req,
    output logic [2:0]         sound_select,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               done,
    output logic               preempted
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    localparam logic [DUR_W-1:0] GAP_CNT = DUR_W'(GAP_FRAMES);

    // Play length of a source; a zero slice still plays one frame.
    function automatic logic [DUR_W-1:0] f_load(input logic [2:0] idx);
        logic [DUR_W-1:0] v;
        v = DUR_FRAMES[int'(idx)*DUR_W +: DUR_W];
        return (v == '0) ? DUR_W'(1) : v;
    endfunction

    // Frame tick: two-flop synchronizer plus an edge-detect flop.
    logic r_fs1, r_fs2, r_fs3;
    logic w_tick;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fs1 <= 1'b0;
            r_fs2 <= 1'b0;
            r_fs3 <= 1'b0;
        end else begin
            r_fs1 <= frame_clk;
            r_fs2 <= r_fs1;
            r_fs3 <= r_fs2;
        end
    end

    assign w_tick = r_fs2 & ~r_fs3;

    state_t               r_state, w_state_n;
    logic [2:0]           r_cur, w_cur_n;
    logic [DUR_W-1:0]     r_cnt, w_cnt_n;
    logic [NUM_REQ-1:0]   r_pend, w_pend_n;
    logic [2:0]           r_sel, w_sel_n;
    logic [NUM_REQ-1:0]   r_grant, w_grant_n;
    logic                 r_busy;
    logic                 r_done, w_done_n;
    logic                 r_pre, w_pre_n;

    logic [NUM_REQ-1:0]   w_cand;
    logic [NUM_REQ-1:0]   w_win_mask;
    logic [2:0]           w_win;
    logic                 w_any;
    logic                 w_retrig;

    assign w_cand = r_pend | req;
    assign w_any  = |w_cand;

    // Highest set index wins; later iterations override earlier ones.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_cand[i]) w_win = 3'(i);
        end
    end

    assign w_win_mask = NUM_REQ'(1) << w_win;
    // r_grant is the one-hot of the playing source, so this is req[cur].
    assign w_retrig   = |(req & r_grant);

    always_comb begin
        w_state_n = r_state;
        w_cur_n   = r_cur;
        w_cnt_n   = r_cnt;
        w_sel_n   = r_sel;
        w_grant_n = r_grant;
        w_done_n  = 1'b0;
        w_pre_n   = 1'b0;
        w_pend_n  = r_pend | req;

        if (flush) begin
            w_state_n = S_IDLE;
            w_pend_n  = '0;
            w_sel_n   = '0;
            w_grant_n = '0;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        w_state_n = S_PLAY;
                        w_cur_n   = w_win;
                        w_cnt_n   = f_load(w_win);
                        w_sel_n   = w_win + 3'd1;
                        w_grant_n = w_win_mask;
                        w_pend_n  = w_pend_n & ~w_win_mask;
                    end
                end
                S_PLAY: begin
                    // The playing source is never queued behind itself, and a
                    // preempted source is dropped rather than re-queued.
                    w_pend_n = w_pend_n & ~r_grant;
                    if (w_any && (w_win > r_cur)) begin
                        w_cur_n   = w_win;
                        w_cnt_n   = f_load(w_win);
                        w_sel_n   = w_win + 3'd1;
                        w_grant_n = w_win_mask;
                        w_pre_n   = 1'b1;
                        w_pend_n  = w_pend_n & ~w_win_mask;
                    end else if (w_retrig) begin
                        w_cnt_n = f_load(r_cur);
                    end else if (w_tick) begin
                        if (r_cnt > DUR_W'(1)) begin
                            w_cnt_n = r_cnt - DUR_W'(1);
                        end else begin
                            w_done_n  = 1'b1;
                            w_sel_n   = '0;
                            w_grant_n = '0;
                            if (GAP_CNT == '0) begin
                                w_state_n = S_IDLE;
                                w_cnt_n   = '0;
                            end else begin
                                w_state_n = S_GAP;
                                w_cnt_n   = GAP_CNT;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_cnt <= DUR_W'(1)) begin
                            w_state_n = S_IDLE;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_sel_n   = '0;
                    w_grant_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pre   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cur   <= w_cur_n;
            r_cnt   <= w_cnt_n;
            r_pend  <= w_pend_n;
            r_sel   <= w_sel_n;
            r_grant <= w_grant_n;
            r_busy  <= (w_state_n != S_IDLE);
            r_done  <= w_done_n;
            r_pre   <= w_pre_n;
        end
    end

    assign sound_select = r_sel;
    assign grant        = r_grant;
    assign busy         = r_busy;
    assign done         = r_done;
    assign preempted    = r_pre;

endmodule

// File: tb/tb_sfx_arbiter.sv
module tb_sfx_arbiter;

    localparam int NR  = 3;
    localparam int GAP = 2;
    int DUR [NR] = '{10, 15, 90};   // jump, coin, game over

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_clk = 1'b0;
    logic          flush = 1'b0;
    logic [NR-1:0] req = '0;
    logic [2:0]    sound_select;
    logic [NR-1:0] grant;
    logic          busy, done, preempted;

    sfx_arbiter #(
        .NUM_REQ   (NR),
        .DUR_W     (8),
        .DUR_FRAMES({8'd90, 8'd15, 8'd10}),
        .GAP_FRAMES(GAP)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .flush       (flush),
        .req         (req),
        .sound_select(sound_select),
        .grant       (grant),
        .busy        (busy),
        .done        (done),
        .preempted   (preempted)
    );

    always #10 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 playing source m_cur, 2 silent gap.
    int       m_mode = 0;
    int       m_cur  = 0;
    int       m_rem  = 0;
    bit [2:0] m_pend = '0;
    bit       m_done = 0, m_pre = 0;
    bit       h1 = 0, h2 = 0, h3 = 0;   // frame_clk as seen 1/2/3 edges ago

    task automatic model_step();
        bit       tk;
        bit [2:0] cand, one;
        int       win;
        one    = 3'b001;
        tk     = h2 && !h3;
        m_done = 0;
        m_pre  = 0;
        if (Reset) begin
            m_mode = 0; m_pend = '0; m_rem = 0;
        end else if (flush) begin
            m_mode = 0; m_pend = '0; m_rem = 0;
        end else begin
            cand = m_pend | req;
            win  = -1;
            for (int i = 0; i < NR; i++) if (cand[i]) win = i;
            case (m_mode)
                0: begin
                    m_pend = cand;
                    if (win >= 0) begin
                        m_mode = 1; m_cur = win; m_rem = DUR[win];
                        m_pend = cand & ~(one << win);
                    end
                end
                1: begin
                    if (win > m_cur) begin
                        m_pre  = 1;
                        m_pend = cand & ~(one << win) & ~(one << m_cur);
                        m_cur  = win;
                        m_rem  = DUR[win];
                    end else begin
                        m_pend = cand & ~(one << m_cur);
                        if (req[m_cur]) m_rem = DUR[m_cur];
                        else if (tk) begin
                            if (m_rem > 1) m_rem--;
                            else begin
                                m_done = 1;
                                m_mode = (GAP > 0) ? 2 : 0;
                                m_rem  = GAP;
                            end
                        end
                    end
                end
                default: begin
                    m_pend = cand;
                    if (tk) begin
                        m_rem--;
                        if (m_rem <= 0) begin m_mode = 0; m_rem = 0; end
                    end
                end
            endcase
        end
        if (Reset) begin h1 = 0; h2 = 0; h3 = 0; end
        else begin h3 = h2; h2 = h1; h1 = frame_clk; end
    endtask

    bit rnd_fc = 0;
    int fc_cnt = 0;

    // Apply one cycle of inputs, advance DUT and model, compare at negedge.
    task automatic cyc(input logic [NR-1:0] r, input logic f, input logic rs);
        logic [NR-1:0] eg;
        req   = r;
        flush = f;
        Reset = rs;
        if (rnd_fc) begin
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
        end else begin
            fc_cnt++;
            frame_clk = fc_cnt[1];
        end
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        eg = (m_mode == 1) ? NR'(1) << m_cur : '0;
        chk("sel",   32'(sound_select), (m_mode == 1) ? 32'(m_cur + 1) : 32'd0);
        chk("grant", 32'(grant),        32'(eg));
        chk("busy",  32'(busy),         32'(m_mode != 0));
        chk("done",  32'(done),         32'(m_done));
        chk("pre",   32'(preempted),    32'(m_pre));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset, jump at cycle 10, 10 frames then 2 gap frames
        for (int i = 0; i < 3; i++) cyc('0, 1'b0, 1'b1);
        idle_n(7);
        cyc(3'b001, 1'b0, 1'b0);
        idle_n(60);
        // 2: coin and jump together; coin first, jump after coin + gap
        cyc(3'b011, 1'b0, 1'b0);
        idle_n(130);
        // 3: jump preempted by game over, not replayed afterwards
        cyc(3'b001, 1'b0, 1'b0);
        idle_n(10);
        cyc(3'b100, 1'b0, 1'b0);
        idle_n(400);
        // 4: coin retriggered late in its effect
        cyc(3'b010, 1'b0, 1'b0);
        idle_n(48);
        cyc(3'b010, 1'b0, 1'b0);
        idle_n(80);
        // 5: flush with a simultaneous higher request while busy
        cyc(3'b001, 1'b0, 1'b0);
        idle_n(6);
        cyc(3'b010, 1'b0, 1'b0);
        cyc(3'b100, 1'b1, 1'b0);
        idle_n(20);
        // 6: reset during play with jump pending
        cyc(3'b010, 1'b0, 1'b0);
        idle_n(5);
        cyc(3'b001, 1'b0, 1'b0);
        idle_n(5);
        cyc('0, 1'b0, 1'b1);
        idle_n(80);
        // random traffic with an irregular frame clock
        rnd_fc = 1;
        for (int i = 0; i < 4000; i++) begin
            logic [NR-1:0] r;
            for (int b = 0; b < NR; b++) r[b] = ($urandom_range(0, 39) == 0);
            cyc(r, $urandom_range(0, 299) == 0, $urandom_range(0, 999) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
